key_result_display: RTL and testbench
=====================================

// Module: key_result_display
// PURPOSE
//  Downstream of the RC4 key-search FSM. Consumes the live secret_key and the search-outcome strobes.
//  Latches the winning key and drives six HEX displays plus the LEDs: live key (rate-limited) while
//  searching, steady key when found, dash pattern + blinking LED when the key space is exhausted.
// PARAMETERS
//  REFRESH_DIV  5_000_000   clk cycles between live-key snapshots while SEARCHING (10 Hz @ 50 MHz)
//  BLINK_DIV    25_000_000  clk cycles per half-period of the status blink
// PORTS
//  clk            in   1   system clock; the only clock
//  reset_n        in   1   asynchronous, active-low reset
//  secret_key     in   24  key currently under test, from the search FSM
//  search_active  in   1   high while the search FSM is between START and FINISH
//  key_found      in   1   1-cycle strobe: current secret_key decrypted successfully
//  key_exhausted  in   1   1-cycle strobe: failure at secret_key == 24'hFFFFFF
//  HEX0..HEX5     out  7   active-low segments; HEX0 = secret_key[3:0] ... HEX5 = [23:20]
//  LEDR           out  10  LEDR[9] = status, LEDR[8] = result_valid, LEDR[7:0] = see CONFIGURATION
//  found_key      out  24  latched winning key
//  result_valid   out  1   high once a key is latched (FOUND), sticky until reset
// BEHAVIOUR
//  - Reset (reset_n low, async): state=IDLE; HEX0..5=7'h7F (blank); LEDR=0; found_key=0;
//    result_valid=0; snapshot register=0; both dividers=0.
//  - States: IDLE, SEARCHING, FOUND, EXHAUSTED; evaluated every posedge, priority top to bottom:
//    any state except FOUND/EXHAUSTED, key_found=1 -> FOUND (found beats exhausted if simultaneous);
//    IDLE/SEARCHING, key_exhausted=1 -> EXHAUSTED;
//    IDLE, search_active=1 -> SEARCHING;  SEARCHING, search_active=0 -> IDLE;
//    FOUND, EXHAUSTED: terminal until reset_n asserted. Strobes in terminal states are ignored.
//  - Latching: at the edge where key_found is sampled high (non-terminal state), found_key <= secret_key
//    and result_valid <= 1 in that same edge. found_key never changes again until reset.
//  - Refresh divider counts 0..REFRESH_DIV-1 in SEARCHING only, wraps to 0; on wrap (and on the
//    IDLE->SEARCHING edge) snapshot <= secret_key. Divider cleared on leaving SEARCHING.
//  - Blink divider free-runs 0..BLINK_DIV-1 from reset; toggles blink bit on wrap.
//  - HEX outputs registered: reflect state/data one cycle after the deciding edge.
//    IDLE: blank. SEARCHING: hex of snapshot. FOUND: hex of found_key, steady.
//    EXHAUSTED: all digits 7'h3F (centre dash only).
//  - Hex encoding (active-low, gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//    A=08 b=03 C=46 d=21 E=06 F=0E.
//  - LEDR[9]: IDLE 0, SEARCHING blink bit, FOUND 1, EXHAUSTED blink bit. LEDR[8] = result_valid.
//  - Divider widths sized by $clog2 of the parameter; REFRESH_DIV, BLINK_DIV >= 2 required.
// CONFIGURATION
//  PROGRESS_BAR_EN defined: LEDR[7:0] is a thermometer of search progress while SEARCHING:
//    lit count = snapshot[23:21]+1 (LEDR[0] first); FOUND/EXHAUSTED hold the last bar; IDLE = 0.
//  PROGRESS_BAR_EN undefined: LEDR[7:0] tied to 8'h00 in every state; no extra logic.
// TESTING  (sim params REFRESH_DIV=4, BLINK_DIV=8)
//  - reset_n low mid-SEARCHING with key 24'h123456 -> same instant HEX*=7F, LEDR=0, result_valid=0.
//  - search_active=1, secret_key increments each clk from 0 -> HEX updates only every 4 clks,
//    first snapshot 0 at entry; LEDR[9] toggles every 8 clks.
//  - key_found pulse with secret_key=24'h00A3B1 -> next edge found_key=00A3B1, result_valid=1;
//    HEX5..0 = 40,40,08,30,03,79; later key_exhausted pulse ignored.
//  - key_exhausted pulse at secret_key=FFFFFF -> EXHAUSTED, HEX*=3F, LEDR[8]=0, LEDR[9] blinks.
//  - key_found and key_exhausted high same cycle -> FOUND, found_key = secret_key of that cycle.
//  - PROGRESS_BAR_EN: snapshot 24'hA00000 -> LEDR[7:0]=8'h3F; undefined -> LEDR[7:0]=0.

Source files
------------

// File: rtl/key_result_display.sv
// key_result_display: latches the winning RC4 key and drives six HEX digits plus LEDR.
// While searching, the displayed key is a snapshot refreshed every REFRESH_DIV cycles; when the
// key space is exhausted the digits show dashes and LEDR[9] blinks.
// Optional feature macro: PROGRESS_BAR_EN (LEDR[7:0] thermometer of search progress).
module key_result_display #(
    parameter int unsigned REFRESH_DIV = 5_000_000,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] secret_key,
    input  logic        search_active,
    input  logic        key_found,
    input  logic        key_exhausted,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [9:0]  LEDR,
    output logic [23:0] found_key,
    output logic        result_valid
);

    localparam int unsigned RefW   = $clog2(REFRESH_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);
    localparam logic [RefW-1:0]   RefLast   = RefW'(REFRESH_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegDash  = 7'h3F;

    typedef enum logic [1:0] {
        StIdle,
        StSearching,
        StFound,
        StExhausted
    } state_e;

    state_e state_q, state_d;

    logic [23:0]       found_key_q, found_key_d;
    logic              result_valid_q, result_valid_d;
    logic [23:0]       snap_q, snap_d;
    logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic [5:0][6:0]   hex_q, hex_d;
    logic              status_q, status_d;
    logic              latch_found;

    // Active-low seven-segment encoding, gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] seg;
        unique case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Next state: a found key wins over exhaustion; terminal states ignore all strobes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (key_found)          state_d = StFound;
                else if (key_exhausted) state_d = StExhausted;
                else if (search_active) state_d = StSearching;
            end
            StSearching: begin
                if (key_found)           state_d = StFound;
                else if (key_exhausted)  state_d = StExhausted;
                else if (!search_active) state_d = StIdle;
            end
            default: state_d = state_q;
        endcase
    end

    // Result latch: captured once on the accepted key_found strobe.
    always_comb begin
        latch_found    = key_found && (state_q == StIdle || state_q == StSearching);
        found_key_d    = latch_found ? secret_key : found_key_q;
        result_valid_d = result_valid_q | latch_found;
    end

    // Refresh divider and live-key snapshot; divider only runs while staying in SEARCHING.
    always_comb begin
        ref_cnt_d = '0;
        snap_d    = snap_q;
        if (state_q == StSearching && state_d == StSearching) begin
            if (ref_cnt_q == RefLast) begin
                snap_d = secret_key;
            end else begin
                ref_cnt_d = ref_cnt_q + RefW'(1);
            end
        end
        if (state_q == StIdle && state_d == StSearching) begin
            snap_d = secret_key;
        end
    end

    // Free-running blink divider.
    always_comb begin
        blink_d = blink_q;
        if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
        end
    end

    // Display contents, registered one cycle behind the state they reflect.
    always_comb begin
        hex_d    = {6{SegBlank}};
        status_d = 1'b0;
        unique case (state_q)
            StSearching: begin
                for (int i = 0; i < 6; i++) hex_d[i] = hex7(snap_q[4*i +: 4]);
                status_d = blink_q;
            end
            StFound: begin
                for (int i = 0; i < 6; i++) hex_d[i] = hex7(found_key_q[4*i +: 4]);
                status_d = 1'b1;
            end
            StExhausted: begin
                hex_d    = {6{SegDash}};
                status_d = blink_q;
            end
            default: begin
                hex_d    = {6{SegBlank}};
                status_d = 1'b0;
            end
        endcase
    end

    // Core state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            found_key_q    <= '0;
            result_valid_q <= 1'b0;
            snap_q         <= '0;
            ref_cnt_q      <= '0;
            blink_cnt_q    <= '0;
            blink_q        <= 1'b0;
            hex_q          <= {6{SegBlank}};
            status_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            found_key_q    <= found_key_d;
            result_valid_q <= result_valid_d;
            snap_q         <= snap_d;
            ref_cnt_q      <= ref_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_q        <= blink_d;
            hex_q          <= hex_d;
            status_q       <= status_d;
        end
    end

`ifdef PROGRESS_BAR_EN
    logic [7:0] bar_q, bar_d;

    // Thermometer of snapshot[23:21]+1 while searching; held in terminal states.
    always_comb begin
        bar_d = bar_q;
        unique case (state_q)
            StIdle:      bar_d = 8'h00;
            StSearching: bar_d = 8'hFF >> (3'd7 - snap_q[23:21]);
            default:     bar_d = bar_q;
        endcase
    end

    // Progress bar register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bar_q <= 8'h00;
        else          bar_q <= bar_d;
    end

    assign LEDR[7:0] = bar_q;
`else
    assign LEDR[7:0] = 8'h00;
`endif

    assign LEDR[9]      = status_q;
    assign LEDR[8]      = result_valid_q;
    assign found_key    = found_key_q;
    assign result_valid = result_valid_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_key_result_display.sv
// Self-checking bench for key_result_display (REFRESH_DIV=4, BLINK_DIV=8).
module tb_key_result_display;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] secret_key = '0;
    logic        search_active = 1'b0;
    logic        key_found = 1'b0;
    logic        key_exhausted = 1'b0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]  LEDR;
    logic [23:0] found_key;
    logic        result_valid;

    int total = 0;
    int bad = 0;

    logic [41:0] exp_disp_q[$];
    logic [23:0] exp_key_q[$];

    key_result_display #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .secret_key   (secret_key),
        .search_active(search_active),
        .key_found    (key_found),
        .key_exhausted(key_exhausted),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3),
        .HEX4         (HEX4),
        .HEX5         (HEX5),
        .LEDR         (LEDR),
        .found_key    (found_key),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
            4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
            4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
            4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] disp(input logic [23:0] k);
        disp = {enc(k[23:20]), enc(k[19:16]), enc(k[15:12]),
                enc(k[11:8]), enc(k[7:4]), enc(k[3:0])};
    endfunction

    function automatic logic [41:0] hex_all();
        hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset released 1 time unit after an edge: the next edge is the first counted one.
    task automatic do_reset();
        reset_n = 1'b0;
        search_active = 1'b0;
        key_found = 1'b0;
        key_exhausted = 1'b0;
        secret_key = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({hex_all(), LEDR, found_key, result_valid} !== {{6{7'h7F}}, 10'h0, 24'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got hex=%h ledr=%h key=%h rv=%b", hex_all(), LEDR,
                     found_key, result_valid);
        end
        search_active = 1'b1;
        secret_key = 24'h123456;
        repeat (5) tick();
        total++;
        if (hex_all() !== disp(24'h123456)) begin
            bad++;
            $display("FAIL pre_reset_hex: got %h want %h", hex_all(), disp(24'h123456));
        end
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({hex_all(), LEDR, result_valid} !== {{6{7'h7F}}, 10'h0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got hex=%h ledr=%h rv=%b want blank/0/0", hex_all(),
                     LEDR, result_valid);
        end
    endtask

    task automatic test_searching();
        logic [41:0] cur;
        cur = '0;
        do_reset();
        search_active = 1'b1;
        for (int n = 0; n < 24; n++) begin
            secret_key = 24'(n);
            tick();
            if (n == 0) begin
                total++;
                if (hex_all() !== {6{7'h7F}}) begin
                    bad++;
                    $display("FAIL search_entry_blank: got %h want blank", hex_all());
                end
            end else begin
                if ((n - 1) % 4 == 0 && exp_disp_q.size() > 0) cur = exp_disp_q.pop_front();
                total++;
                if (hex_all() !== cur) begin
                    bad++;
                    $display("FAIL search_hex[%0d]: got %h want %h", n, hex_all(), cur);
                end
            end
            total++;
            if (LEDR[9] !== 1'((n / 8) % 2)) begin
                bad++;
                $display("FAIL search_blink[%0d]: got %b want %b", n, LEDR[9], 1'((n / 8) % 2));
            end
            if (n % 4 == 0) exp_disp_q.push_back(disp(24'(n)));
        end
        exp_disp_q.delete();
        search_active = 1'b0;
        tick();
        tick();
        total++;
        if ({hex_all(), LEDR[9]} !== {{6{7'h7F}}, 1'b0}) begin
            bad++;
            $display("FAIL search_to_idle: got hex=%h led9=%b want blank/0", hex_all(), LEDR[9]);
        end
    endtask

    task automatic test_found();
        logic [23:0] ek;
        do_reset();
        search_active = 1'b1;
        repeat (3) tick();
        secret_key = 24'h00A3B1;
        key_found = 1'b1;
        exp_key_q.push_back(24'h00A3B1);
        tick();
        key_found = 1'b0;
        secret_key = 24'h00A3B2;
        ek = exp_key_q.pop_front();
        total++;
        if ({found_key, result_valid, LEDR[8]} !== {ek, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL found_latch: got key=%h rv=%b led8=%b want %h/1/1", found_key,
                     result_valid, LEDR[8], ek);
        end
        tick();
        total++;
        if (hex_all() !== {7'h40, 7'h40, 7'h08, 7'h30, 7'h03, 7'h79}) begin
            bad++;
            $display("FAIL found_hex: got %h want 40,40,08,30,03,79", hex_all());
        end
        total++;
        if (LEDR[9] !== 1'b1) begin
            bad++;
            $display("FAIL found_status: got %b want 1", LEDR[9]);
        end
        secret_key = 24'hFFFFFF;
        key_exhausted = 1'b1;
        tick();
        key_exhausted = 1'b0;
        secret_key = 24'h111111;
        key_found = 1'b1;
        tick();
        key_found = 1'b0;
        repeat (2) tick();
        total++;
        if ({found_key, result_valid, hex_all()} !== {24'h00A3B1, 1'b1, disp(24'h00A3B1)}) begin
            bad++;
            $display("FAIL found_terminal: got key=%h rv=%b hex=%h want 00a3b1/1/steady",
                     found_key, result_valid, hex_all());
        end
    endtask

    task automatic test_exhausted();
        logic prev;
        int changes;
        int first_at;
        int second_at;
        do_reset();
        search_active = 1'b1;
        repeat (2) tick();
        secret_key = 24'hFFFFFF;
        key_exhausted = 1'b1;
        tick();
        key_exhausted = 1'b0;
        tick();
        total++;
        if ({hex_all(), LEDR[8], result_valid, found_key} !== {{6{7'h3F}}, 1'b0, 1'b0, 24'h0})
        begin
            bad++;
            $display("FAIL exhausted_disp: got hex=%h led8=%b rv=%b key=%h", hex_all(),
                     LEDR[8], result_valid, found_key);
        end
        prev = LEDR[9];
        changes = 0;
        first_at = -1;
        second_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (LEDR[9] !== prev) begin
                changes++;
                if (first_at < 0) first_at = i;
                else if (second_at < 0) second_at = i;
            end
            prev = LEDR[9];
        end
        total++;
        if (changes < 2 || (second_at - first_at) != 8) begin
            bad++;
            $display("FAIL exhausted_blink: got %0d toggles spacing %0d want >=2 spacing 8",
                     changes, second_at - first_at);
        end
        secret_key = 24'h000042;
        key_found = 1'b1;
        tick();
        key_found = 1'b0;
        tick();
        total++;
        if ({result_valid, found_key, hex_all()} !== {1'b0, 24'h0, {6{7'h3F}}}) begin
            bad++;
            $display("FAIL exhausted_terminal: got rv=%b key=%h hex=%h want 0/0/dashes",
                     result_valid, found_key, hex_all());
        end
    endtask

    task automatic test_simultaneous();
        logic [23:0] ek;
        do_reset();
        search_active = 1'b1;
        tick();
        secret_key = 24'h5A5A5A;
        key_found = 1'b1;
        key_exhausted = 1'b1;
        exp_key_q.push_back(24'h5A5A5A);
        tick();
        key_found = 1'b0;
        key_exhausted = 1'b0;
        secret_key = 24'h5A5A5B;
        ek = exp_key_q.pop_front();
        total++;
        if ({found_key, result_valid} !== {ek, 1'b1}) begin
            bad++;
            $display("FAIL simultaneous_latch: got %h/%b want %h/1", found_key, result_valid, ek);
        end
        tick();
        total++;
        if (hex_all() !== disp(ek)) begin
            bad++;
            $display("FAIL simultaneous_hex: got %h want %h", hex_all(), disp(ek));
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] ek;
        do_reset();
        secret_key = 24'h0C0FFE;
        key_found = 1'b1;
        exp_key_q.push_back(24'h0C0FFE);
        tick();
        secret_key = 24'h777777;
        tick();
        key_found = 1'b0;
        tick();
        ek = exp_key_q.pop_front();
        total++;
        if ({found_key, result_valid, hex_all()} !== {ek, 1'b1, disp(ek)}) begin
            bad++;
            $display("FAIL idle_found: got key=%h rv=%b hex=%h want %h/1/%h", found_key,
                     result_valid, hex_all(), ek, disp(ek));
        end
    endtask

    task automatic test_progress();
        logic [7:0] exp_bar;
`ifdef PROGRESS_BAR_EN
        exp_bar = 8'h3F;
`else
        exp_bar = 8'h00;
`endif
        do_reset();
        search_active = 1'b1;
        secret_key = 24'hA00000;
        tick();
        secret_key = 24'hA00001;
        tick();
        total++;
        if (LEDR[7:0] !== exp_bar) begin
            bad++;
            $display("FAIL progress_bar: got %h want %h", LEDR[7:0], exp_bar);
        end
        key_found = 1'b1;
        tick();
        key_found = 1'b0;
        repeat (2) tick();
        total++;
        if (LEDR[7:0] !== exp_bar) begin
            bad++;
            $display("FAIL progress_hold: got %h want %h", LEDR[7:0], exp_bar);
        end
    endtask

    initial begin
        test_reset();
        test_searching();
        test_found();
        test_exhausted();
        test_simultaneous();
        test_back_to_back();
        test_progress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
